button_event_classifier: RTL and testbench

BUTTON_EVENT_CLASSIFIER -- requirements
Module: button_event_classifier

---
 rtl/btn_pkg.sv | 17 +
 rtl/ms_tick_gen.sv | 37 +++
 rtl/button_event_classifier.sv | 133 +++++++++++++
 tb/tb_button_event_classifier.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared state encodings and default timing parameters for the button event classifier.
// Pure declarations; no logic, no latency.
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        WAIT_GAP  = 3'd2,
        PRESS2    = 3'd3,
        LONG_HOLD = 3'd4
    } btn_state_e;

    localparam int DEF_PRESCALE = 50000;
    localparam int DEF_LONG_MS  = 800;
    localparam int DEF_GAP_MS   = 300;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond strobe generator: counts 0..PRESCALE-1 and strobes ms_tick on the wrap cycle.
// clr restarts the count on the next edge; free-running, no backpressure.
module ms_tick_gen #(
    parameter int PRESCALE = btn_pkg::DEF_PRESCALE
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    output logic ms_tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          wrap;

    always_comb begin
        wrap = (cnt_q == CW'(PRESCALE - 1));
        if (clr || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ms_tick = wrap;

endmodule

// File: rtl/button_event_classifier.sv
// Classifies debounced presses into short, double and long events plus a hold level.
// Pulses appear one cycle after the deciding sample; all outputs registered, no backpressure.
module button_event_classifier
    import btn_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE,
    parameter int LONG_MS  = DEF_LONG_MS,
    parameter int GAP_MS   = DEF_GAP_MS
) (
    input  logic clk,
    input  logic reset_n,
    input  logic db_level,
    input  logic db_tick,
    output logic short_tick,
    output logic double_tick,
    output logic long_tick,
    output logic hold
);

    localparam int MW = $clog2(LONG_MS + 1);

    btn_state_e    state_q;
    btn_state_e    state_d;
    logic [MW-1:0] ms_q;
    logic [MW-1:0] ms_d;
    logic          lvl_q;
    logic          short_q;
    logic          short_d;
    logic          double_q;
    logic          double_d;
    logic          long_q;
    logic          long_d;
    logic          hold_q;
    logic          hold_d;
    logic          clr;
    logic          ms_tick;
    logic          fall;

    ms_tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_ms_tick_gen (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (clr),
        .ms_tick(ms_tick)
    );

    always_comb begin
        state_d  = state_q;
        clr      = 1'b0;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        fall     = lvl_q & ~db_level;

        // Release is checked before expiry so a simultaneous release/timeout keeps the press short.
        case (state_q)
            IDLE: begin
                if (db_tick) begin
                    state_d = PRESS1;
                    clr     = 1'b1;
                end
            end
            PRESS1: begin
                if (fall) begin
                    state_d = WAIT_GAP;
                    clr     = 1'b1;
                end else if (ms_q == MW'(LONG_MS) && db_level) begin
                    state_d = LONG_HOLD;
                    long_d  = 1'b1;
                end
            end
            WAIT_GAP: begin
                if (db_tick) begin
                    state_d = PRESS2;
                end else if (ms_q == MW'(GAP_MS)) begin
                    state_d = IDLE;
                    short_d = 1'b1;
                end
            end
            PRESS2: begin
                if (fall) begin
                    state_d  = IDLE;
                    double_d = 1'b1;
                end
            end
            LONG_HOLD: begin
                if (fall) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        hold_d = (state_d == LONG_HOLD);

        if (clr) begin
            ms_d = '0;
        end else if (ms_tick && (ms_q != {MW{1'b1}})) begin
            ms_d = ms_q + MW'(1);
        end else begin
            ms_d = ms_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ms_q     <= '0;
            lvl_q    <= 1'b0;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            hold_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ms_q     <= ms_d;
            lvl_q    <= db_level;
            short_q  <= short_d;
            double_q <= double_d;
            long_q   <= long_d;
            hold_q   <= hold_d;
        end
    end

    assign short_tick  = short_q;
    assign double_tick = double_q;
    assign long_tick   = long_q;
    assign hold        = hold_q;

endmodule

// File: tb/tb_button_event_classifier.sv
// Scoreboard bench: stimulus queues expected events with their cycle stamps,
// a monitor pops and compares each observed pulse or hold edge.
module tb_button_event_classifier;

    localparam int P = 4;
    localparam int L = 8;
    localparam int G = 3;

    logic clk = 1'b0;
    logic reset_n;
    logic db_level;
    logic db_tick;
    logic short_tick;
    logic double_tick;
    logic long_tick;
    logic hold;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef enum int {EV_LONG, EV_HOLD_RISE, EV_HOLD_FALL, EV_SHORT, EV_DOUBLE} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       at;
    } ev_t;

    ev_t exp_q[$];

    button_event_classifier #(
        .PRESCALE(P),
        .LONG_MS (L),
        .GAP_MS  (G)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .db_level   (db_level),
        .db_tick    (db_tick),
        .short_tick (short_tick),
        .double_tick(double_tick),
        .long_tick  (long_tick),
        .hold       (hold)
    );

    always #10 clk = ~clk;

    // cyc == k after the k-th rising edge; an input set at a negedge with cyc == k is sampled at edge k+1.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_ev(input ev_kind_e k, input int at);
        ev_t e;
        e.kind = k;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_e k);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected %s at cycle %0d: got event, required none", k.name(), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.at != cyc) begin
                bad++;
                $display("FAIL event: got %s@%0d, required %s@%0d", k.name(), cyc, e.kind.name(), e.at);
            end
        end
    endtask

    task automatic check_eq(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic press_at(input int s);
        wait_to(s - 1);
        db_tick  = 1'b1;
        db_level = 1'b1;
        @(negedge clk);
        db_tick  = 1'b0;
    endtask

    task automatic tick_at(input int s);
        wait_to(s - 1);
        db_tick = 1'b1;
        @(negedge clk);
        db_tick = 1'b0;
    endtask

    task automatic release_at(input int s);
        wait_to(s - 1);
        db_level = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_short"},  short_tick,  1'b0);
        check_eq({tag, "_double"}, double_tick, 1'b0);
        check_eq({tag, "_long"},   long_tick,   1'b0);
        check_eq({tag, "_hold"},   hold,        1'b0);
    endtask

    initial begin : monitor
        logic hold_prev;
        hold_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (long_tick)              observe(EV_LONG);
            if (hold && !hold_prev)     observe(EV_HOLD_RISE);
            if (!hold && hold_prev)     observe(EV_HOLD_FALL);
            if (short_tick)             observe(EV_SHORT);
            if (double_tick)            observe(EV_DOUBLE);
            hold_prev = hold;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: stimulus did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int e;
        reset_n  = 1'b0;
        db_level = 1'b0;
        db_tick  = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Short press: clear on release edge r, 3 ms = 12 cycles, plus one registered cycle.
        e = cyc + 2;
        expect_ev(EV_SHORT, e + 10 + 13);
        press_at(e);
        release_at(e + 10);
        wait_to(e + 40);

        // Long press: 8 ms = 32 cycles after the tick edge, pulse seen one cycle later.
        e = cyc + 2;
        expect_ev(EV_LONG,      e + 33);
        expect_ev(EV_HOLD_RISE, e + 33);
        expect_ev(EV_HOLD_FALL, e + 50);
        press_at(e);
        wait_to(e + 40);
        check_eq("hold_mid_long", hold, 1'b1);
        release_at(e + 50);
        wait_to(e + 70);

        // Double click: 8-cycle press, 6-cycle gap, 8-cycle press.
        e = cyc + 2;
        expect_ev(EV_DOUBLE, e + 22);
        press_at(e);
        release_at(e + 8);
        press_at(e + 14);
        release_at(e + 22);
        wait_to(e + 45);

        // Second tick lands on the very edge that samples the gap expiry.
        e = cyc + 2;
        expect_ev(EV_DOUBLE, e + 25);
        press_at(e);
        release_at(e + 8);
        press_at(e + 8 + 13);
        release_at(e + 25);
        wait_to(e + 50);

        // Release coincides with the long-press expiry: treated as short.
        e = cyc + 2;
        expect_ev(EV_SHORT, e + 33 + 13);
        press_at(e);
        release_at(e + 33);
        wait_to(e + 70);

        // Reset during the gap: no short pulse may follow.
        e = cyc + 2;
        press_at(e);
        release_at(e + 5);
        wait_to(e + 8);
        reset_n = 1'b0;
        #1;
        check_all_zero("rst_gap");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        wait_to(e + 40);

        // Reset mid-press with the level still high: no event without a fresh tick.
        e = cyc + 2;
        press_at(e);
        wait_to(e + 4);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        release_at(e + 20);
        wait_to(e + 60);

        // Stray ticks in PRESS1 and LONG_HOLD must not disturb timing or hold.
        e = cyc + 2;
        expect_ev(EV_LONG,      e + 33);
        expect_ev(EV_HOLD_RISE, e + 33);
        expect_ev(EV_HOLD_FALL, e + 45);
        press_at(e);
        tick_at(e + 5);
        tick_at(e + 40);
        wait_to(e + 41);
        check_eq("hold_after_stray_tick", hold, 1'b1);
        release_at(e + 45);
        wait_to(e + 65);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing events: got %0d left over, required 0 (first %s@%0d)",
                     exp_q.size(), exp_q[0].kind.name(), exp_q[0].at);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
